// File: rtl/uart_cmd_receive_if.sv
// Handshake bundle between the UART byte source / command FIFO and the
// command receiver. The receiver takes the slave view; the byte source and
// FIFO model take the master view.
`timescale 1ns/1ps
interface uart_cmd_receive_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         cmd_fifo_full;
  logic         cmd_fifo_wr;
  logic [159:0] cmd_data;
  logic         hdr_err;
  logic         timeout_err;
  logic         overflow_err;
  logic [15:0]  pkt_count;
  logic [7:0]   err_count;

  modport master (
    output rx_valid, rx_data, cmd_fifo_full,
    input  cmd_fifo_wr, cmd_data, hdr_err, timeout_err, overflow_err,
           pkt_count, err_count
  );

  modport slave (
    input  rx_valid, rx_data, cmd_fifo_full,
    output cmd_fifo_wr, cmd_data, hdr_err, timeout_err, overflow_err,
           pkt_count, err_count
  );
endinterface

// File: rtl/uart_cmd_receive.sv
// Frames the host UART byte stream into 160-bit command words.
// 0xFF header -> 20-byte long packet, 0xAA header -> 4-byte short packet.
// Each complete packet is written as one word into the command FIFO;
// bad headers, inter-byte timeouts and FIFO-full drops are pulsed and counted.
`timescale 1ns/1ps
module uart_cmd_receive #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  uart_cmd_receive_if.slave bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t         r_state,    w_state_nxt;
  logic [159:0]   r_sr,       w_sr_nxt;
  logic [4:0]     r_rem,      w_rem_nxt;
  logic           r_long,     w_long_nxt;
  logic [TMO_W-1:0] r_tmo,    w_tmo_nxt;
  logic [159:0]   r_cmd_data, w_cmd_data_nxt;
  logic           r_wr,       w_wr;
  logic           r_hdr_err,  w_hdr_err;
  logic           r_to_err,   w_to_err;
  logic           r_ovf_err,  w_ovf_err;
  logic [15:0]    r_pkt_count;
  logic [7:0]     r_err_count;
  logic [159:0]   w_sr_shift;

  assign w_sr_shift = {r_sr[151:0], bus.rx_data};

  // Next-state and next-register computation for the framing FSM
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_rem_nxt      = r_rem;
    w_long_nxt     = r_long;
    w_tmo_nxt      = r_tmo;
    w_cmd_data_nxt = r_cmd_data;
    w_wr           = 1'b0;
    w_hdr_err      = 1'b0;
    w_to_err       = 1'b0;
    w_ovf_err      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          w_tmo_nxt = '0;
          if (bus.rx_data == 8'hFF) begin
            w_sr_nxt    = {152'b0, 8'hFF};
            w_rem_nxt   = 5'd19;
            w_long_nxt  = 1'b1;
            w_state_nxt = S_COLLECT;
          end else if (bus.rx_data == 8'hAA) begin
            w_sr_nxt    = {152'b0, 8'hAA};
            w_rem_nxt   = 5'd3;
            w_long_nxt  = 1'b0;
            w_state_nxt = S_COLLECT;
          end else begin
            w_hdr_err = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (bus.rx_valid) begin
          // Header values inside a packet are plain payload.
          w_sr_nxt  = w_sr_shift;
          w_rem_nxt = r_rem - 5'd1;
          w_tmo_nxt = '0;
          if (r_rem == 5'd1) begin
            w_state_nxt = S_IDLE;
            if (!bus.cmd_fifo_full) begin
              w_wr           = 1'b1;
              w_cmd_data_nxt = r_long ? w_sr_shift : {128'b0, w_sr_shift[31:0]};
            end else begin
              w_ovf_err = 1'b1;
            end
          end
        end else if (r_tmo == TMO_LAST) begin
          w_to_err    = 1'b1;
          w_sr_nxt    = '0;
          w_tmo_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath, strobe and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_rem       <= '0;
      r_long      <= 1'b0;
      r_tmo       <= '0;
      r_cmd_data  <= '0;
      r_wr        <= 1'b0;
      r_hdr_err   <= 1'b0;
      r_to_err    <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      r_state    <= w_state_nxt;
      r_sr       <= w_sr_nxt;
      r_rem      <= w_rem_nxt;
      r_long     <= w_long_nxt;
      r_tmo      <= w_tmo_nxt;
      r_cmd_data <= w_cmd_data_nxt;
      r_wr       <= w_wr;
      r_hdr_err  <= w_hdr_err;
      r_to_err   <= w_to_err;
      r_ovf_err  <= w_ovf_err;
      if (w_wr) r_pkt_count <= r_pkt_count + 16'd1;
      // Error sources are mutually exclusive, so at most one event per cycle.
      if ((w_hdr_err || w_to_err || w_ovf_err) && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.cmd_fifo_wr  = r_wr;
  assign bus.cmd_data     = r_cmd_data;
  assign bus.hdr_err      = r_hdr_err;
  assign bus.timeout_err  = r_to_err;
  assign bus.overflow_err = r_ovf_err;
  assign bus.pkt_count    = r_pkt_count;
  assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_uart_cmd_receive.sv
// Directed bench for uart_cmd_receive with TIMEOUT_CYCLES = 16.
`timescale 1ns/1ps
module tb_uart_cmd_receive;

  localparam logic [159:0] LONG_WORD = 160'hFF0102030405060708090A0B0C0D0E0F10111213;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_cnt = 0, hdr_cnt = 0, to_cnt = 0, ovf_cnt = 0;

  uart_cmd_receive_if bus ();

  uart_cmd_receive #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled well after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.cmd_fifo_wr)  wr_cnt++;
    if (bus.hdr_err)      hdr_cnt++;
    if (bus.timeout_err)  to_cnt++;
    if (bus.overflow_err) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; byte is captured on the next rising edge and
  // the task returns on the falling edge after it.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_short(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(8'hAA);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.cmd_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr",   bus.cmd_fifo_wr, 0);
    check("rst_data", bus.cmd_data, 0);
    check("rst_hdr",  bus.hdr_err, 0);
    check("rst_to",   bus.timeout_err, 0);
    check("rst_ovf",  bus.overflow_err, 0);
    check("rst_pkt",  bus.pkt_count, 0);
    check("rst_err",  bus.err_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Long packet, bytes 10 cycles apart
    for (int i = 0; i < 20; i++) begin
      send_byte((i == 0) ? 8'hFF : 8'(i));
      if (i < 19) repeat (9) @(negedge clk);
    end
    check("long_wr",   bus.cmd_fifo_wr, 1);
    check("long_data", bus.cmd_data, LONG_WORD);
    check("long_pkt",  bus.pkt_count, 1);
    @(negedge clk);
    check("long_wr_pulse", bus.cmd_fifo_wr, 0);
    check("long_wr_cnt",   wr_cnt, 1);

    // Short packet, write one cycle after last byte
    send_short(8'h12, 8'h34, 8'h56);
    check("short_wr",   bus.cmd_fifo_wr, 1);
    check("short_data", bus.cmd_data, {128'b0, 32'hAA123456});
    check("short_pkt",  bus.pkt_count, 2);

    // Bad header then a clean short packet
    send_byte(8'h55);
    check("hdr_pulse", bus.hdr_err, 1);
    check("hdr_errcnt", bus.err_count, 1);
    @(negedge clk);
    check("hdr_pulse_end", bus.hdr_err, 0);
    send_short(8'h01, 8'h02, 8'h03);
    check("hdr_short_data", bus.cmd_data, {128'b0, 32'hAA010203});
    check("hdr_short_pkt",  bus.pkt_count, 3);
    check("hdr_wr_cnt",     wr_cnt, 3);

    // Timeout after FF + 5 bytes
    for (int i = 0; i < 6; i++) send_byte((i == 0) ? 8'hFF : 8'(i));
    repeat (15) @(negedge clk);
    check("to_early", bus.timeout_err, 0);
    @(negedge clk);
    check("to_pulse",  bus.timeout_err, 1);
    check("to_errcnt", bus.err_count, 2);
    check("to_no_wr",  wr_cnt, 3);
    send_short(8'hDE, 8'hAD, 8'h01);
    check("to_next_data", bus.cmd_data, {128'b0, 32'hAADEAD01});
    check("to_next_pkt",  bus.pkt_count, 4);

    // Byte arriving exactly at expiry keeps the packet alive
    for (int i = 0; i < 6; i++) send_byte((i == 0) ? 8'hFF : 8'(i));
    repeat (15) @(negedge clk);
    send_byte(8'h06);
    check("edge_no_to",  bus.timeout_err, 0);
    check("edge_to_cnt", to_cnt, 1);
    for (int i = 7; i < 20; i++) send_byte(8'(i));
    check("edge_data", bus.cmd_data, LONG_WORD);
    check("edge_pkt",  bus.pkt_count, 5);

    // FIFO full during last byte of a short packet
    send_byte(8'hAA);
    send_byte(8'h77);
    send_byte(8'h88);
    bus.cmd_fifo_full = 1'b1;
    send_byte(8'h99);
    bus.cmd_fifo_full = 1'b0;
    check("ovf_pulse",  bus.overflow_err, 1);
    check("ovf_no_wr",  bus.cmd_fifo_wr, 0);
    check("ovf_pkt",    bus.pkt_count, 5);
    check("ovf_hold",   bus.cmd_data, LONG_WORD);
    check("ovf_errcnt", bus.err_count, 3);
    @(negedge clk);
    check("ovf_cnt", ovf_cnt, 1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_byte(8'h55);
    @(negedge clk);
    check("sat_errcnt", bus.err_count, 8'hFF);
    check("sat_hdr_cnt", hdr_cnt, 301);

    // Reset in the middle of a long packet
    for (int i = 0; i < 8; i++) send_byte((i == 0) ? 8'hFF : 8'(i));
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", bus.cmd_data, 0);
    check("mid_rst_pkt",  bus.pkt_count, 0);
    check("mid_rst_err",  bus.err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_short(8'h12, 8'h34, 8'h56);
    check("post_rst_data", bus.cmd_data, {128'b0, 32'hAA123456});
    check("post_rst_pkt",  bus.pkt_count, 1);
    check("post_rst_wr",   wr_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
